mem_dump_reader: RTL

MEM_DUMP_READER -- requirements
Module: mem_dump_reader

---
 rtl/mem_dump_reader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_dump_reader.sv
// mem_dump_reader
//   Streams word_count consecutive memory words, starting at start_addr, to a
//   valid/ready consumer. Reads are issued only when the 2-entry output FIFO
//   is guaranteed to have room for the returning word. So the consumer can
//   stall arbitrarily without words being lost or duplicated.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start, start_addr,
//   word_count              dump request (sampled only when idle)
//   busy, done              dump in progress / one-cycle completion pulse
//   mem_rd_en, mem_rd_addr  memory read strobe and address
//   mem_rd_data             read data, valid the cycle after mem_rd_en
//   out_valid, out_data,
//   out_addr, out_ready     dumped word stream (valid/ready handshake)
module mem_dump_reader #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [15:0]       word_count,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              out_ready
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] next_addr;
   logic [15:0]       remaining;
   logic              inflight;       // a read was issued last cycle; its data is on mem_rd_data now
   logic [ADDR_W-1:0] inflight_addr;
   logic [1:0]        fifo_count;
   logic [DATA_W-1:0] fifo_data [2];  // entry 0 is the head
   logic [ADDR_W-1:0] fifo_addr [2];

   logic       pop;
   logic       push;
   logic [2:0] occupancy;
   logic       wr_slot;

   assign out_valid   = (fifo_count != 2'd0);
   assign out_data    = fifo_data[0];
   assign out_addr    = fifo_addr[0];
   assign pop         = out_valid & out_ready;
   assign push        = inflight;
   assign mem_rd_addr = next_addr;

   // Words that will still be held after this cycle's push/pop. A new read
   // lands in the FIFO one cycle later, so it may only be issued while this
   // is below the FIFO depth. Counting the pop keeps throughput at one word
   // per cycle while the consumer is ready.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
   assign mem_rd_en = (state == READ) && (remaining != 16'd0) && (occupancy < 3'd2);

   // Incoming word goes behind whatever survives this cycle's pop.
   assign wr_slot = ((fifo_count - {1'b0, pop}) != 2'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         next_addr     <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         fifo_count    <= 2'd0;
         fifo_data[0]  <= '0;
         fifo_data[1]  <= '0;
         fifo_addr[0]  <= '0;
         fifo_addr[1]  <= '0;
      end else begin
         done     <= 1'b0;
         inflight <= mem_rd_en;

         if (mem_rd_en) begin
            inflight_addr <= next_addr;
            next_addr     <= next_addr + ADDR_W'(1);   // wraps naturally
            remaining     <= remaining - 16'd1;
         end

         fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            fifo_data[0] <= fifo_data[1];
            fifo_addr[0] <= fifo_addr[1];
         end
         // Placed after the shift so a push into slot 0 overrides it.
         if (push) begin
            if (wr_slot) begin
               fifo_data[1] <= mem_rd_data;
               fifo_addr[1] <= inflight_addr;
            end else begin
               fifo_data[0] <= mem_rd_data;
               fifo_addr[0] <= inflight_addr;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  next_addr <= start_addr;
                  remaining <= word_count;
                  busy      <= 1'b1;
                  state     <= (word_count == 16'd0) ? FIN : READ;
               end
            end
            READ: begin
               if (remaining == 16'd0 || (mem_rd_en && remaining == 16'd1))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (fifo_count == 2'd0 && !inflight)
                  state <= FIN;
            end
            FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
